// File: rtl/ll_cred_pkg.sv
// ll_cred_pkg: widths and helpers shared by the logic-link credit blocks.
//   LL_CRED_RET_W - width of the per-cycle credit-return vector
//   LL_CRED_CNT_W - width of credit counters
//   cred_therm()  - count (0..4) -> thermometer code, one set bit per credit
package ll_cred_pkg;

  localparam int LL_CRED_RET_W = 4;
  localparam int LL_CRED_CNT_W = 8;

  typedef logic [LL_CRED_CNT_W-1:0] cred_cnt_t;
  typedef logic [LL_CRED_RET_W-1:0] cred_ret_t;

  function automatic cred_ret_t cred_therm(input logic [2:0] n);
    cred_ret_t t;
    t = '0;
    for (int k = 0; k < LL_CRED_RET_W; k++) t[k] = (int'(n) > k);
    return t;
  endfunction

endpackage

// File: rtl/ll_rx_cred.sv
// ll_rx_cred: receive-side credit block of the logic link.
// Turns received push-bit words into RX FIFO pushes, counts RX FIFO pops and
// hands them back to the far-end transmitter as credits, and advertises the
// initial credit (FIFO_DEPTH) each time the link comes online.
//
// Ports
//   clk_wr, rst_wr_n    clock, asynchronous active-low reset
//   rx_online           link online; low clears all state except dbg_cred_err
//   rx_i_pushbit        received word valid
//   rxfifo_i_push       RX FIFO write strobe (combinational)
//   rxfifo_i_full       RX FIFO full
//   rxfifo_i_pop        RX FIFO read strobe
//   init_i_credit[7:0]  initial credit advertised to the far end
//   tx_i_credit[3:0]    credit-return vector, each set bit = one credit
//   dbg_pending_credit  credits popped but not yet returned
//   dbg_cred_err        sticky credit violation
//
// Parameters
//   ASYMMETRIC_CREDIT   1: return up to 4 credits/cycle; 0: 1 credit/cycle on bit 0
//   FIFO_DEPTH          RX FIFO depth, advertised as the initial credit
//
// Build option
//   LL_RX_CRED_CHECK_EN  adds the outstanding-credit checker; blocks pushes while
//                        full and drives dbg_cred_err. Without it dbg_cred_err = 0.
module ll_rx_cred
  import ll_cred_pkg::*;
#(
  parameter logic       ASYMMETRIC_CREDIT = 1'b1,
  parameter logic [7:0] FIFO_DEPTH        = 8'd16
) (
  input  logic       clk_wr,
  input  logic       rst_wr_n,
  input  logic       rx_online,
  input  logic       rx_i_pushbit,
  output logic       rxfifo_i_push,
  input  logic       rxfifo_i_full,
  input  logic       rxfifo_i_pop,
  output logic [7:0] init_i_credit,
  output logic [3:0] tx_i_credit,
  output logic [7:0] dbg_pending_credit,
  output logic       dbg_cred_err
);

  logic       rx_online_dly;
  logic       online_rise;
  logic       pop_q;
  cred_cnt_t  pend;
  logic [2:0] ret_n;

  assign online_rise = rx_online & ~rx_online_dly;
  assign pop_q       = rxfifo_i_pop & rx_online;

  // Return amount comes from the pending count before this cycle's pop, so a
  // pop is never returned in the cycle it arrives.
  always_comb begin
    ret_n = '0;
    if (ASYMMETRIC_CREDIT) ret_n = (pend > 8'd4) ? 3'd4 : pend[2:0];
    else                   ret_n = {2'b00, pend != '0};
  end

  // Going offline discards pending credits outright; the next online edge
  // re-advertises the full depth, so nothing partial may leak out.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rx_online_dly <= 1'b0;
      pend          <= '0;
      init_i_credit <= '0;
      tx_i_credit   <= '0;
    end else if (!rx_online) begin
      rx_online_dly <= 1'b0;
      pend          <= '0;
      init_i_credit <= '0;
      tx_i_credit   <= '0;
    end else begin
      rx_online_dly <= 1'b1;
      pend          <= pend + {7'd0, pop_q} - {5'd0, ret_n};
      tx_i_credit   <= cred_therm(ret_n);
      if (online_rise) init_i_credit <= FIFO_DEPTH;
    end
  end

  assign dbg_pending_credit = pend;

`ifdef LL_RX_CRED_CHECK_EN
  // Outstanding = credits the far end holds. A received word spends one
  // whether or not the FIFO accepts it, so the word itself (not the gated
  // push) is what decrements it; the decrement saturates so one violation
  // does not wrap the count.
  cred_cnt_t outst;
  logic      word_seen;
  logic      cred_err;

  assign word_seen     = rx_i_pushbit & rx_online;
  assign rxfifo_i_push = word_seen & ~rxfifo_i_full;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      outst    <= '0;
      cred_err <= 1'b0;
    end else begin
      // Sticky across rx_online; only reset clears it.
      if (word_seen && ((outst == '0) || rxfifo_i_full)) cred_err <= 1'b1;
      if (!rx_online)       outst <= '0;
      else if (online_rise) outst <= FIFO_DEPTH;
      else                  outst <= outst - {7'd0, (word_seen && (outst != '0))}
                                           + {5'd0, ret_n};
    end
  end

  assign dbg_cred_err = cred_err;
`else
  logic unused_full;

  assign unused_full   = rxfifo_i_full;
  assign rxfifo_i_push = rx_i_pushbit & rx_online;
  assign dbg_cred_err  = 1'b0;
`endif

endmodule

// File: doc/ll_rx_cred.md
Name: ll_rx_cred

Overview:
Receive-side credit block of the logic link, peer of the transmit credit counter.
- Accepts push-bit-qualified words from the link and generates RX FIFO pushes.
- Counts RX FIFO pops and returns them as credits on a 4-bit credit-return vector to the far-end transmitter.
- Advertises the initial credit count when the link comes online.

Parameters:
ASYMMETRIC_CREDIT, 1'b1, 1 = return up to 4 credits/cycle on all 4 bits; 0 = return at most 1 credit/cycle on bit 0 only
FIFO_DEPTH, 8'd16, RX FIFO depth in words; the advertised initial credit (1..255)

Ports:
clk_wr  input  1  clock
rst_wr_n  input  1  asynchronous active-low reset
rx_online  input  1  link online; low clears all state except the optional sticky error
rx_i_pushbit  input  1  received word valid
rxfifo_i_push  output  1  RX FIFO write strobe
rxfifo_i_full  input  1  RX FIFO full
rxfifo_i_pop  input  1  RX FIFO read strobe, synchronous to clk_wr
init_i_credit  output  8  initial credit advertised to far end
tx_i_credit  output  4  credit-return vector; each set bit = one credit
dbg_pending_credit  output  8  credits popped but not yet returned
dbg_cred_err  output  1  sticky credit violation (0 when feature absent)

Behaviour:
Reset values:
- All outputs and registers reset to 0.
- rx_online_dly resets to 0.

Push path (combinational):
- rxfifo_i_push = rx_i_pushbit & rx_online.
- With the feature compiled in, also gated by ~rxfifo_i_full.

Initial credit:
- init_i_credit is registered.
- Loads FIFO_DEPTH on the cycle after the rising edge of rx_online (rx_online & ~rx_online_dly).
- Holds that value while rx_online = 1; forced to 0 when rx_online = 0.

Pending counter (8-bit):
- pop_q = rxfifo_i_pop & rx_online.
- pend_nxt = pend + pop_q - ret_n.
- Cleared to 0 when rx_online = 0; pops while offline are ignored.
- Never exceeds FIFO_DEPTH in legal operation; no wrap handling is required.

Return amount (computed from the current pend, before this cycle's pop):
- Asymmetric: ret_n = min(pend, 4).
- Symmetric: ret_n = (pend != 0).

Credit return:
- tx_i_credit is registered from ret_n as thermometer code: bit k = (ret_n > k).
- Latency: pop at cycle N → pend increments at N+1 → credit bit asserted at N+2.
- Simultaneous pop and return in the same cycle: both apply (net = +1 - ret_n).
- tx_i_credit = 0 whenever rx_online was 0 in the previous cycle.

Reset or rx_online drop mid-stream:
- Pending credits are discarded; no partial return.
- The next online rising edge re-advertises the full FIFO_DEPTH.

Optional Feature:
Macro: LL_RX_CRED_CHECK_EN

Defined:
- An 8-bit outstanding counter tracks credits the far end currently holds: out_nxt = out - push + ret_n.
- It loads FIFO_DEPTH on the online rising edge and clears when offline.
- A push when out == 0, or rx_i_pushbit while rxfifo_i_full, sets dbg_cred_err.
- dbg_cred_err is sticky until rst_wr_n; it is not cleared by rx_online.
- Pushes are blocked while full.

Not defined:
- No outstanding counter.
- dbg_cred_err tied to 0.
- rxfifo_i_push is not gated by full.

Decomposition:
Shared package ll_cred_pkg:
- LL_CRED_RET_W = 4
- LL_CRED_CNT_W = 8
- function cred_therm(n) for count → thermometer encoding

Sub-module: none required. The optional checker may be a small sub-module, ll_rx_cred_chk.

Test Plan:
- Online rise with FIFO_DEPTH = 16 → init_i_credit = 16 one cycle after the edge; tx_i_credit = 0; pend = 0.
- Asym mode, 6 pops in one burst cycle-by-cycle → tx_i_credit sums to exactly 6, each bit asserted no earlier than 2 cycles after its pop.
- Symmetric mode, 3 back-to-back pops → tx_i_credit = 4'b0001 for 3 consecutive cycles starting at pop+2; bits [3:1] always 0.
- Drop rx_online with pend = 5 → pend = 0 next cycle, no credits returned; re-online → init_i_credit = 16.
- LL_RX_CRED_CHECK_EN, 17 pushes with no pops after init 16 → dbg_cred_err = 1 on the 17th push and stays set through an rx_online toggle.
- Reset asserted mid-traffic → all outputs 0 asynchronously; after release, behaviour matches a fresh online rise.
